writeback_unit: RTL

WRITEBACK_UNIT -- requirements
Module: writeback_unit

---
 rtl/writeback_unit_pkg.sv | 16 +
 rtl/writeback_unit_wb_fifo.sv | 51 +++++
 rtl/writeback_unit.sv | 95 +++++++++
 3 files changed

// File: rtl/writeback_unit_pkg.sv
// Shared types and default sizes for the writeback unit and its load buffer.
package writeback_unit_pkg;

    // Types
    typedef logic [4:0]  reg_id_t;
    typedef logic [31:0] op_t;

    typedef struct packed {
        reg_id_t rd;
        op_t     data;
    } wb_req_t;

    // Parameters
    localparam int LD_FIFO_DEPTH_DEFAULT = 2;

endpackage

// File: rtl/writeback_unit_wb_fifo.sv
// Synchronous FIFO of writeback requests; accepts a push while full if a pop happens in the same cycle.
module wb_fifo
    import writeback_unit_pkg::*;
#(
    parameter int DEPTH = LD_FIFO_DEPTH_DEFAULT
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  wb_req_t push_data,
    input  logic    pop,
    output wb_req_t pop_data,
    output logic    full,
    output logic    empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_req_t       mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/writeback_unit.sv
// Register-file writeback arbiter: buffered loads beat the ALU, one write per cycle.
// Optional busy scoreboard is built only when ASTRIO_WB_SCOREBOARD_EN is defined.
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int LD_FIFO_DEPTH = LD_FIFO_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  reg_id_t     alu_rd,
    input  op_t         alu_data,
    output logic        alu_ready,
    input  logic        ld_valid,
    input  reg_id_t     ld_rd,
    input  op_t         ld_data,
    output logic        ld_ready,
    input  logic        issue_valid,
    input  reg_id_t     issue_rd,
    output logic        enable_write,
    output reg_id_t     write_id,
    output op_t         write_data,
    output logic [31:0] busy,
    output logic [31:0] retired_count
);

    wb_req_t fifo_head;
    wb_req_t sel;
    logic    fifo_full;
    logic    fifo_empty;
    logic    sel_valid;

    // Both sources look ready while reset is held so upstream never stalls on it.
    assign ld_ready  = rst || !fifo_full;
    assign alu_ready = rst || fifo_empty;

    wb_fifo #(
        .DEPTH(LD_FIFO_DEPTH)
    ) u_ld_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (ld_valid && ld_ready),
        .push_data(wb_req_t'{rd: ld_rd, data: ld_data}),
        .pop      (!fifo_empty),
        .pop_data (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign sel_valid = !fifo_empty || alu_valid;
    assign sel       = fifo_empty ? wb_req_t'{rd: alu_rd, data: alu_data} : fifo_head;

    always_ff @(posedge clk) begin
        if (rst) begin
            enable_write  <= 1'b0;
            write_id      <= '0;
            write_data    <= '0;
            retired_count <= '0;
        end else begin
            enable_write <= sel_valid && (sel.rd != '0);
            if (sel_valid) begin
                write_id   <= sel.rd;
                write_data <= sel.data;
            end
            if (sel_valid && (sel.rd != '0)) begin
                retired_count <= retired_count + 32'd1;
            end
        end
    end

`ifdef ASTRIO_WB_SCOREBOARD_EN
    logic [31:0] busy_next;

    // Clear first so a same-cycle reissue of the written register keeps it busy.
    always_comb begin
        busy_next = busy;
        if (enable_write) busy_next[write_id] = 1'b0;
        if (issue_valid && (issue_rd != '0)) busy_next[issue_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end
`else
    logic issue_unused;
    assign issue_unused = issue_valid ^ (^issue_rd);
    assign busy         = '0;
`endif

endmodule
